// File: rtl/llki_mask_pkg.sv
// Shared types for the LLKI keystream mask: key loader states and state width.
package llki_mask_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2,
      ERROR  = 2'd3
   } key_state_e;

endpackage : llki_mask_pkg

// File: rtl/llki_mask_lane.sv
// One masked data channel: rotating slice counter, XOR with the selected mask slice,
// and the registered output stage.
module llki_mask_lane #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SLICES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cnt_clr_i,
   input  logic                     in_valid_i,
   input  logic [DATA_W-1:0]        in_data_i,
   input  logic [SLICES*DATA_W-1:0] mask_i,
   output logic                     out_valid_o,
   output logic [DATA_W-1:0]        out_data_o
);

   localparam int unsigned CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;

   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [DATA_W-1:0] slice_c;

   assign slice_c = mask_i[cnt_q*DATA_W +: DATA_W];

   // Counter advances per beat; a clear (key change) overrides a same-cycle beat.
   always_comb begin
      cnt_d = cnt_q;
      if (in_valid_i) begin
         cnt_d = (cnt_q == CNT_W'(SLICES - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
      if (cnt_clr_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= in_valid_i;
         if (in_valid_i) begin
            out_data_q <= in_data_i ^ slice_c;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule : llki_mask_lane

// File: rtl/llki_keystream_mask.sv
// LLKI key gate: loads a multi-word key over valid/ready and XOR-masks NUM_CH write-data
// channels with slices of (EXP_KEY ^ loaded key); data is clean only with the right key.
module llki_keystream_mask
   import llki_mask_pkg::*;
#(
   parameter int unsigned               KEY_WORDS = 2,
   parameter int unsigned               KEY_W     = 64,
   parameter int unsigned               DATA_W    = 32,
   parameter int unsigned               NUM_CH    = 3,
   parameter logic [KEY_WORDS*KEY_W-1:0] EXP_KEY  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     key_valid,
   output logic                     key_ready,
   input  logic [KEY_W-1:0]         key_data,
   input  logic                     key_last,
   input  logic                     cmd_clear,
   output logic [STATE_W-1:0]       key_state,
   output logic                     key_match,
   input  logic [NUM_CH-1:0]        ch_in_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
   output logic [NUM_CH-1:0]        ch_out_valid,
   output logic [NUM_CH*DATA_W-1:0] ch_out_data
);

   localparam int unsigned KEY_TOT_W = KEY_WORDS * KEY_W;
   localparam int unsigned SLICES    = KEY_TOT_W / DATA_W;
   localparam int unsigned PTR_W     = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

   if ((KEY_TOT_W % DATA_W) != 0) begin : g_bad_cfg
      $error("llki_keystream_mask: KEY_WORDS*KEY_W must be a multiple of DATA_W");
   end

   key_state_e           state_q;
   logic [KEY_TOT_W-1:0] key_reg_q;
   logic [PTR_W-1:0]     wr_ptr_q;
   logic                 key_ready_q;
   logic                 key_match_q;

   logic                 beat_c;
   logic                 last_word_c;
   logic                 enter_loaded_c;
   logic [KEY_TOT_W-1:0] mask_c;

   // cmd_clear wins over a key beat offered in the same cycle.
   assign beat_c         = key_valid & key_ready_q & ~cmd_clear;
   assign last_word_c    = (wr_ptr_q == PTR_W'(KEY_WORDS - 1));
   assign enter_loaded_c = beat_c & key_last & last_word_c;
   assign mask_c         = EXP_KEY ^ ((state_q == LOADED) ? key_reg_q : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         key_reg_q   <= '0;
         wr_ptr_q    <= '0;
         key_ready_q <= 1'b1;
         key_match_q <= 1'b0;
      end else begin
         key_match_q <= (state_q == LOADED) && (key_reg_q == EXP_KEY);
         if (cmd_clear) begin
            state_q     <= IDLE;
            key_reg_q   <= '0;
            wr_ptr_q    <= '0;
            key_ready_q <= 1'b1;
         end else if (beat_c) begin
            // Word 0 lands in the MSBs of the key register.
            for (int unsigned w = 0; w < KEY_WORDS; w++) begin
               if (wr_ptr_q == PTR_W'(w)) begin
                  key_reg_q[(KEY_WORDS-1-w)*KEY_W +: KEY_W] <= key_data;
               end
            end
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (key_last) begin
               state_q     <= last_word_c ? LOADED : ERROR;
               key_ready_q <= 1'b0;
            end else begin
               state_q     <= last_word_c ? ERROR : LOAD;
               key_ready_q <= ~last_word_c;
            end
         end
      end
   end

   assign key_ready = key_ready_q;
   assign key_state = state_q;
   assign key_match = key_match_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      llki_mask_lane #(
         .DATA_W (DATA_W),
         .SLICES (SLICES)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .cnt_clr_i   (cmd_clear | enter_loaded_c),
         .in_valid_i  (ch_in_valid[c]),
         .in_data_i   (ch_in_data[c*DATA_W +: DATA_W]),
         .mask_i      (mask_c),
         .out_valid_o (ch_out_valid[c]),
         .out_data_o  (ch_out_data[c*DATA_W +: DATA_W])
      );
   end

endmodule : llki_keystream_mask

// File: tb/tb_llki_keystream_mask.sv
// Directed bench for llki_keystream_mask with a reference model and expected-data scoreboard.
module tb_llki_keystream_mask;

   localparam logic [127:0] EXP = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
   localparam logic [63:0]  W0  = 64'h0011223344556677;
   localparam logic [63:0]  W1  = 64'h8899AABBCCDDEEFF;

   typedef struct {
      int          ch;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key_data;
   logic        key_last;
   logic        cmd_clear;
   logic [1:0]  key_state;
   logic        key_match;
   logic [2:0]  ch_in_valid;
   logic [95:0] ch_in_data;
   logic [2:0]  ch_out_valid;
   logic [95:0] ch_out_data;

   int n_pass  = 0;
   int n_total = 0;

   exp_t        sb[$];
   logic [1:0]  m_state;
   logic [127:0] m_key;
   int          m_ptr;
   int          m_cnt[3];
   logic        m_match;

   always #5 clk = ~clk;

   llki_keystream_mask #(
      .KEY_WORDS (2),
      .KEY_W     (64),
      .DATA_W    (32),
      .NUM_CH    (3),
      .EXP_KEY   (EXP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .key_data     (key_data),
      .key_last     (key_last),
      .cmd_clear    (cmd_clear),
      .key_state    (key_state),
      .key_match    (key_match),
      .ch_in_valid  (ch_in_valid),
      .ch_in_data   (ch_in_data),
      .ch_out_valid (ch_out_valid),
      .ch_out_data  (ch_out_data)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: model the cycle from the spec, push expectations, then compare after the edge.
   task automatic step();
      logic [127:0] m;
      logic [2:0]   vld;
      exp_t         e;
      logic [1:0]   n_state;
      logic [127:0] n_key;
      int           n_ptr;
      int           n_cnt[3];
      logic         n_match;
      m   = EXP ^ ((m_state == 2'd2) ? m_key : 128'h0);
      vld = ch_in_valid;
      for (int c = 0; c < 3; c++) begin
         n_cnt[c] = m_cnt[c];
         if (vld[c]) begin
            e.ch   = c;
            e.data = ch_in_data[c*32 +: 32] ^ m[m_cnt[c]*32 +: 32];
            sb.push_back(e);
            n_cnt[c] = (m_cnt[c] == 3) ? 0 : m_cnt[c] + 1;
         end
      end
      n_match = (m_state == 2'd2) && (m_key == EXP);
      n_state = m_state;
      n_key   = m_key;
      n_ptr   = m_ptr;
      if (cmd_clear) begin
         n_state = 2'd0;
         n_key   = '0;
         n_ptr   = 0;
         for (int c = 0; c < 3; c++) n_cnt[c] = 0;
      end else if (key_valid && (m_state == 2'd0 || m_state == 2'd1)) begin
         n_key[(1-m_ptr)*64 +: 64] = key_data;
         n_ptr = m_ptr + 1;
         if (key_last) n_state = (m_ptr == 1) ? 2'd2 : 2'd3;
         else          n_state = (m_ptr == 1) ? 2'd3 : 2'd1;
         if (n_state == 2'd2) for (int c = 0; c < 3; c++) n_cnt[c] = 0;
      end
      @(posedge clk);
      m_state = n_state;
      m_key   = n_key;
      m_ptr   = n_ptr;
      m_match = n_match;
      for (int c = 0; c < 3; c++) m_cnt[c] = n_cnt[c];
      #1;
      chk("key_state", 128'(key_state), 128'(m_state));
      chk("key_ready", 128'(key_ready), 128'(m_state < 2'd2));
      chk("key_match", 128'(key_match), 128'(m_match));
      chk("out_valid", 128'(ch_out_valid), 128'(vld));
      for (int c = 0; c < 3; c++) begin
         if (vld[c]) begin
            e = sb.pop_front();
            chk($sformatf("ch%0d_data", e.ch), 128'(ch_out_data[e.ch*32 +: 32]), 128'(e.data));
         end
      end
   endtask

   task automatic key_beat(input logic [63:0] d, input logic last);
      key_valid = 1'b1;
      key_data  = d;
      key_last  = last;
      step();
      key_valid = 1'b0;
      key_last  = 1'b0;
   endtask

   task automatic ch_beat(input logic [2:0] v, input logic [95:0] d);
      ch_in_valid = v;
      ch_in_data  = d;
      step();
      ch_in_valid = '0;
   endtask

   task automatic clear();
      cmd_clear = 1'b1;
      step();
      cmd_clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_rot[5];
      logic [31:0] d[6];
      exp_rot[0] = 32'hCCDD_EEFF; exp_rot[1] = 32'h8899_AABB; exp_rot[2] = 32'h4455_6677;
      exp_rot[3] = 32'h0011_2233; exp_rot[4] = 32'hCCDD_EEFF;

      rst = 1'b1; key_valid = 1'b0; key_data = '0; key_last = 1'b0; cmd_clear = 1'b0;
      ch_in_valid = '0; ch_in_data = '0;
      m_state = 2'd0; m_key = '0; m_ptr = 0; m_match = 1'b0;
      for (int c = 0; c < 3; c++) m_cnt[c] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 128'(key_state), 128'(0));
      chk("rst_ready", 128'(key_ready), 128'(1));
      chk("rst_match", 128'(key_match), 128'(0));
      chk("rst_out_valid", 128'(ch_out_valid), 128'(0));
      chk("rst_out_data", 128'(ch_out_data), 128'(0));
      rst = 1'b0;

      // No key: zero data reveals the EXP_KEY slices in rotation.
      for (int i = 0; i < 5; i++) begin
         ch_beat(3'b001, 96'h0);
         chk($sformatf("nokey_rot%0d", i), 128'(ch_out_data[31:0]), 128'(exp_rot[i]));
      end

      // Correct key.
      key_beat(W0, 1'b0);
      chk("load_state", 128'(key_state), 128'(1));
      key_beat(W1, 1'b1);
      chk("loaded_state", 128'(key_state), 128'(2));
      step();
      chk("good_match", 128'(key_match), 128'(1));
      ch_beat(3'b111, {3{32'hDEAD_BEEF}});
      chk("good_pass", 128'(ch_out_data), 128'({3{32'hDEAD_BEEF}}));

      // Wrong key: LSB of word 1 flipped.
      clear();
      key_beat(W0, 1'b0);
      key_beat(W1 ^ 64'h1, 1'b1);
      step();
      chk("bad_match", 128'(key_match), 128'(0));
      ch_beat(3'b001, 96'h0);
      chk("bad_mask", 128'(ch_out_data[31:0]), 128'(32'h1));
      for (int i = 0; i < 4; i++) ch_beat(3'b111, {$urandom, $urandom, $urandom});

      // Short key -> ERROR.
      clear();
      key_beat(W0, 1'b1);
      chk("short_err", 128'(key_state), 128'(3));
      chk("short_ready", 128'(key_ready), 128'(0));
      ch_beat(3'b100, 96'h0);
      chk("err_mask", 128'(ch_out_data[95:64]), 128'(32'hCCDD_EEFF));
      clear();
      chk("clr_idle", 128'(key_state), 128'(0));
      chk("clr_ready", 128'(key_ready), 128'(1));

      // Long key -> ERROR.
      key_beat(W0, 1'b0);
      key_beat(W1, 1'b0);
      chk("long_err", 128'(key_state), 128'(3));
      clear();

      // Clear and key beat in the same cycle: beat dropped, next full key loads cleanly.
      cmd_clear = 1'b1;
      key_beat(W0, 1'b0);
      cmd_clear = 1'b0;
      chk("drop_idle", 128'(key_state), 128'(0));
      key_beat(W0, 1'b0);
      key_beat(W1, 1'b1);
      step();
      chk("drop_match", 128'(key_match), 128'(1));

      // Channel 1 streams while the key loads.
      clear();
      for (int i = 0; i < 6; i++) begin
         d[i] = $urandom;
         ch_in_valid = 3'b010;
         ch_in_data  = {32'h0, d[i], 32'h0};
         if (i == 1) begin
            key_valid = 1'b1; key_data = W0; key_last = 1'b0;
         end else if (i == 2) begin
            key_valid = 1'b1; key_data = W1; key_last = 1'b1;
         end else begin
            key_valid = 1'b0; key_last = 1'b0;
         end
         step();
         if (i == 2) chk("conc_entry", 128'(ch_out_data[63:32]), 128'(d[2] ^ 32'h4455_6677));
         if (i == 3) chk("conc_clean", 128'(ch_out_data[63:32]), 128'(d[3]));
      end
      key_valid = 1'b0;
      ch_in_valid = '0;
      step();
      chk("sb_drained", 128'(sb.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_llki_keystream_mask
